// File: rtl/dht_frame_receiver_pkg.sv
// Shared definitions for the DHT11/DHT22 frame receiver: FSM states, error codes,
// frame byte indices and the frame byte/checksum helpers.
package dht_frame_receiver_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START_LOW,
        S_RELEASE,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_CHECK,
        S_COOLDOWN
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_NO_RESP  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_CHECKSUM = 2'd3;

    // Byte 0 is the first byte on the wire and sits in the frame MSBs.
    localparam int BYTE_HUM_INT  = 0;
    localparam int BYTE_HUM_DEC  = 1;
    localparam int BYTE_TEMP_INT = 2;
    localparam int BYTE_TEMP_DEC = 3;
    localparam int BYTE_CHECKSUM = 4;

    function automatic logic [7:0] frame_byte(input logic [39:0] frame, input int idx);
        logic [39:0] shifted;
        shifted = frame >> (8 * (BYTE_CHECKSUM - idx));
        return shifted[7:0];
    endfunction

    function automatic logic checksum_ok(input logic [39:0] frame);
        logic [7:0] sum;
        sum = frame_byte(frame, BYTE_HUM_INT) + frame_byte(frame, BYTE_HUM_DEC)
            + frame_byte(frame, BYTE_TEMP_INT) + frame_byte(frame, BYTE_TEMP_DEC);
        return sum == frame_byte(frame, BYTE_CHECKSUM);
    endfunction

endpackage

// File: rtl/dht_frame_receiver_us_tick.sv
// Free-running prescaler producing a one-cycle tick every microsecond of CLK_FREQ_HZ.
// With a 1 MHz clock the tick is permanently high.
module dht_frame_receiver_us_tick #(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);
    localparam int DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || r_cnt == LAST) r_cnt <= '0;
        else                      r_cnt <= r_cnt + 1'b1;
    end

    assign o_tick = (r_cnt == LAST);
endmodule

// File: rtl/dht_frame_receiver.sv
// DHT11/DHT22 single-wire host: start pulse, response/bit timing, checksum, result bytes.
// Define DHT_DEGLITCH_EN to filter the synchronised pad level (3 agreeing samples).
module dht_frame_receiver
    import dht_frame_receiver_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int START_LOW_US  = 18000,
    parameter int TIMEOUT_US    = 100,
    parameter int BIT_THRESH_US = 48,
    parameter int COOLDOWN_MS   = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        dht_in,
    output logic        dht_oe,
    output logic        busy,
    output logic        data_valid,
    output logic        err_valid,
    output logic [1:0]  err_code,
    output logic [7:0]  hum_int,
    output logic [7:0]  hum_dec,
    output logic [7:0]  temp_int,
    output logic [7:0]  temp_dec,
    output logic [39:0] raw_frame
);
    localparam logic [15:0] START_LAST = 16'(START_LOW_US - 1);
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_US - 1);
    localparam logic [15:0] BIT_THRESH = 16'(BIT_THRESH_US);
    localparam int          COOL_US    = COOLDOWN_MS * 1000;
    localparam int          CCW        = $clog2(COOL_US + 1);
    localparam logic [CCW-1:0] COOL_LAST = CCW'(COOL_US - 1);

    state_t         r_state, w_state_next;
    logic           w_tick;
    logic [15:0]    r_phase_cnt;
    logic [CCW-1:0] r_cool_cnt;
    logic [1:0]     r_sync;
    logic           w_level, r_level_d, w_rise, w_fall;
    logic           w_phase_to, w_shift, w_bit, w_fail;
    logic [1:0]     w_fail_code;
    logic [39:0]    r_frame, r_raw_frame;
    logic [5:0]     r_bit_cnt;
    logic           r_data_valid, r_err_valid;
    logic [1:0]     r_err_code;
    logic [7:0]     r_hum_int, r_hum_dec, r_temp_int, r_temp_dec;

    dht_frame_receiver_us_tick #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_us_tick (
        .clk    (clk),
        .rst    (rst),
        .o_tick (w_tick)
    );

    // NOTE: every clocked process uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) r_sync <= 2'b11;
        else     r_sync <= {r_sync[0], dht_in};
    end

`ifdef DHT_DEGLITCH_EN
    logic [2:0] r_hist;
    logic       r_filt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 3'b111;
            r_filt <= 1'b1;
        end else begin
            r_hist <= {r_hist[1:0], r_sync[1]};
            if (&r_hist)       r_filt <= 1'b1;
            else if (~|r_hist) r_filt <= 1'b0;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync[1];
`endif

    always_ff @(posedge clk) begin
        if (rst) r_level_d <= 1'b1;
        else     r_level_d <= w_level;
    end

    assign w_rise     = w_level & ~r_level_d;
    assign w_fall     = ~w_level & r_level_d;
    assign w_phase_to = w_tick && (r_phase_cnt == TO_LAST);
    assign w_bit      = (r_phase_cnt > BIT_THRESH);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_shift      = 1'b0;
        w_fail       = 1'b0;
        w_fail_code  = ERR_NONE;
        dht_oe       = (r_state == S_START_LOW);
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:      if (start) w_state_next = S_START_LOW;
            S_START_LOW: if (w_tick && r_phase_cnt == START_LAST) w_state_next = S_RELEASE;
            S_RELEASE: begin
                if (w_fall) w_state_next = S_RESP_LOW;
                else if (w_phase_to) begin
                    w_state_next = S_COOLDOWN;
                    w_fail       = 1'b1;
                    w_fail_code  = ERR_NO_RESP;
                end
            end
            S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH: begin
                if ((r_state == S_RESP_LOW) && w_rise)       w_state_next = S_RESP_HIGH;
                else if ((r_state == S_RESP_HIGH) && w_fall) w_state_next = S_BIT_LOW;
                else if ((r_state == S_BIT_LOW) && w_rise)   w_state_next = S_BIT_HIGH;
                else if ((r_state == S_BIT_HIGH) && w_fall) begin
                    w_shift      = 1'b1;
                    w_state_next = (r_bit_cnt == 6'd39) ? S_CHECK : S_BIT_LOW;
                end else if (w_phase_to) begin
                    w_state_next = S_COOLDOWN;
                    w_fail       = 1'b1;
                    w_fail_code  = ERR_TIMEOUT;
                end
            end
            S_CHECK:    w_state_next = S_COOLDOWN;
            S_COOLDOWN: if (w_tick && r_cool_cnt == COOL_LAST) w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_state_next != r_state) r_phase_cnt <= '0;
        else if (w_tick)                    r_phase_cnt <= r_phase_cnt + 16'd1;
    end

    // Cooldown outlasts the 16-bit phase counter, so it has its own.
    always_ff @(posedge clk) begin
        if (rst || r_state != S_COOLDOWN) r_cool_cnt <= '0;
        else if (w_tick)                  r_cool_cnt <= r_cool_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame      <= '0;
            r_raw_frame  <= '0;
            r_bit_cnt    <= '0;
            r_data_valid <= 1'b0;
            r_err_valid  <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_hum_int    <= '0;
            r_hum_dec    <= '0;
            r_temp_int   <= '0;
            r_temp_dec   <= '0;
        end else begin
            r_data_valid <= 1'b0;
            r_err_valid  <= 1'b0;
            if (r_state == S_RELEASE) r_bit_cnt <= '0;
            if (w_shift) begin
                r_frame   <= {r_frame[38:0], w_bit};
                r_bit_cnt <= r_bit_cnt + 6'd1;
            end
            if (w_fail) begin
                r_err_valid <= 1'b1;
                r_err_code  <= w_fail_code;
            end
            if (r_state == S_CHECK) begin
                r_raw_frame <= r_frame;
                if (checksum_ok(r_frame)) begin
                    r_data_valid <= 1'b1;
                    r_err_code   <= ERR_NONE;
                    r_hum_int    <= frame_byte(r_frame, BYTE_HUM_INT);
                    r_hum_dec    <= frame_byte(r_frame, BYTE_HUM_DEC);
                    r_temp_int   <= frame_byte(r_frame, BYTE_TEMP_INT);
                    r_temp_dec   <= frame_byte(r_frame, BYTE_TEMP_DEC);
                end else begin
                    r_err_valid <= 1'b1;
                    r_err_code  <= ERR_CHECKSUM;
                end
            end
        end
    end

    assign data_valid = r_data_valid;
    assign err_valid  = r_err_valid;
    assign err_code   = r_err_code;
    assign hum_int    = r_hum_int;
    assign hum_dec    = r_hum_dec;
    assign temp_int   = r_temp_int;
    assign temp_dec   = r_temp_dec;
    assign raw_frame  = r_raw_frame;
endmodule

// File: tb/tb_dht_frame_receiver.sv
// Self-checking bench for dht_frame_receiver: a behavioural sensor drives the pad and a
// frame-level model predicts result bytes, error codes and timing.
`timescale 1ns/1ps
module tb_dht_frame_receiver;
    localparam int START_US = 1000;
    localparam int TO_US    = 100;
    localparam int COOL_US  = 1000;

    logic        clk = 1'b0;
    logic        rst, start, s_low;
    logic        dht_in, dht_oe, busy, data_valid, err_valid;
    logic [1:0]  err_code;
    logic [7:0]  hum_int, hum_dec, temp_int, temp_dec;
    logic [39:0] raw_frame;

    // Open-drain pad with pull-up: low if either host or sensor pulls it down.
    assign dht_in = ~(dht_oe | s_low);

    always #500 clk = ~clk;

    dht_frame_receiver #(
        .CLK_FREQ_HZ  (1_000_000),
        .START_LOW_US (START_US),
        .TIMEOUT_US   (TO_US),
        .BIT_THRESH_US(48),
        .COOLDOWN_MS  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dht_in    (dht_in),
        .dht_oe    (dht_oe),
        .busy      (busy),
        .data_valid(data_valid),
        .err_valid (err_valid),
        .err_code  (err_code),
        .hum_int   (hum_int),
        .hum_dec   (hum_dec),
        .temp_int  (temp_int),
        .temp_dec  (temp_dec),
        .raw_frame (raw_frame)
    );

    int n_checks = 0, n_errors = 0;
    int cyc = 0, n_dv = 0, n_err = 0, n_both = 0, oe_rises = 0, rel_cnt = 0;
    int rel_cyc = 0, err_cyc = 0, busy_fall_cyc = 0;
    logic [1:0] err_seen_code = 2'd0, dv_seen_code = 2'd0;
    logic prev_oe = 1'b0, prev_busy = 1'b0;

    // Expected state: last good bytes, last captured frame.
    logic [31:0] m_bytes = '0;
    logic [39:0] m_raw = '0;

    always @(negedge clk) begin
        cyc++;
        if (data_valid) begin n_dv++; dv_seen_code = err_code; end
        if (err_valid) begin n_err++; err_seen_code = err_code; err_cyc = cyc; end
        if (data_valid && err_valid) n_both++;
        if (dht_oe === 1'b1 && prev_oe === 1'b0) oe_rises++;
        if (dht_oe === 1'b0 && prev_oe === 1'b1) begin rel_cnt++; rel_cyc = cyc; end
        if (busy === 1'b0 && prev_busy === 1'b1) busy_fall_cyc = cyc;
        prev_oe   = dht_oe;
        prev_busy = busy;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(input logic low, input int n);
        s_low = low;
        step(n);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_bytes"}, {hum_int, hum_dec, temp_int, temp_dec}, m_bytes);
        check({tag, "_raw"}, raw_frame, m_raw);
    endtask

    // mode 0: full frame, 1: sensor silent, 2: line stuck high at bit 17.
    task automatic do_txn(input string tag, input logic [39:0] frame, input int mode, input bit poke);
        int dv0, er0, oe0, rc0, sum;
        bit ok, good;
        dv0 = n_dv; er0 = n_err; oe0 = oe_rises; rc0 = rel_cnt;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < START_US + 20; i++) begin
            if (rel_cnt != rc0) begin ok = 1'b1; break; end
            step(1);
        end
        check({tag, "_released"}, ok, 1'b1);
        if (mode != 1) begin
            hold(1'b0, 30);
            hold(1'b1, 80);
            hold(1'b0, 80);
            for (int b = 0; b < 40; b++) begin
                hold(1'b1, $urandom_range(45, 55));
                if (mode == 2 && b == 17) break;
                if (poke && b == 5) pulse_start();
                hold(1'b0, frame[39-b] ? $urandom_range(65, 75) : $urandom_range(20, 30));
            end
            if (mode == 0) hold(1'b1, 50);
            s_low = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (poke && i == 200) pulse_start();
            if (!busy) begin ok = 1'b1; break; end
            step(1);
        end
        check({tag, "_idle_again"}, ok, 1'b1);
        step(5);
        check({tag, "_starts_accepted"}, oe_rises - oe0, 1);
        if (mode == 0) begin
            sum = int'(frame[39:32]) + int'(frame[31:24]) + int'(frame[23:16]) + int'(frame[15:8]);
            good = (sum % 256) == int'(frame[7:0]);
            m_raw = frame;
            if (good) begin
                m_bytes = frame[39:8];
                check({tag, "_dv_pulses"}, n_dv - dv0, 1);
                check({tag, "_err_pulses"}, n_err - er0, 0);
                check({tag, "_dv_code"}, dv_seen_code, 2'd0);
            end else begin
                check({tag, "_dv_pulses"}, n_dv - dv0, 0);
                check({tag, "_err_pulses"}, n_err - er0, 1);
                check({tag, "_err_code"}, err_seen_code, 2'd3);
                check({tag, "_cooldown"}, busy_fall_cyc - err_cyc, COOL_US);
            end
        end else begin
            check({tag, "_dv_pulses"}, n_dv - dv0, 0);
            check({tag, "_err_pulses"}, n_err - er0, 1);
            check({tag, "_err_code"}, err_seen_code, (mode == 1) ? 2'd1 : 2'd2);
            check({tag, "_cooldown"}, busy_fall_cyc - err_cyc, COOL_US);
            if (mode == 1) check({tag, "_no_resp_latency"}, err_cyc - rel_cyc, TO_US);
        end
        check_outputs(tag);
    endtask

    initial begin
        logic [39:0] f;
        logic [7:0]  b0, b1, b2, b3, ck;
        int dv0, er0, oe0;
        rst = 1'b1; start = 1'b0; s_low = 1'b0;
        step(5);
        check("rst_oe", dht_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_dv", data_valid, 1'b0);
        check("rst_ev", err_valid, 1'b0);
        check("rst_code", err_code, 2'd0);
        check_outputs("rst");
        rst = 1'b0;
        step(3);

        do_txn("good", 40'h37_00_19_00_50, 0, 1'b1);
        check("good_hum_int", hum_int, 8'd55);
        check("good_temp_int", temp_int, 8'd25);
        do_txn("badsum", 40'h37_00_19_00_51, 0, 1'b0);
        check("badsum_hum_int", hum_int, 8'd55);
        do_txn("silent", 40'h0, 1, 1'b0);
        do_txn("stuck", 40'hA5_5A_C3_3C_00, 2, 1'b0);

        // Reset in the middle of the start pulse.
        dv0 = n_dv; er0 = n_err; oe0 = oe_rises;
        pulse_start();
        step(200);
        check("mid_start_driving", dht_oe, 1'b1);
        rst = 1'b1;
        step(1);
        check("mid_rst_oe", dht_oe, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        rst = 1'b0;
        step(50);
        check("mid_rst_no_dv", n_dv - dv0, 0);
        check("mid_rst_no_err", n_err - er0, 0);
        m_bytes = '0; m_raw = '0;
        check_outputs("mid_rst");

        // Start coinciding with reset.
        oe0 = oe_rises;
        start = 1'b1; rst = 1'b1;
        step(1);
        start = 1'b0; rst = 1'b0;
        check("start_rst_busy", busy, 1'b0);
        step(5);
        check("start_rst_no_drive", oe_rises - oe0, 0);

        for (int t = 0; t < 3; t++) begin
            b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
            ck = b0 + b1 + b2 + b3;
            if ($urandom_range(0, 1) == 0) ck = ck + 8'($urandom_range(1, 255));
            f = {b0, b1, b2, b3, ck};
            do_txn($sformatf("rand%0d", t), f, 0, t == 1);
        end

        check("never_both_pulses", n_both, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #(150_000 * 1000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end
endmodule
